// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [31:0]     addr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO of {instr, addr} with a one-cycle flush.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic [63:0]                  push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [63:0]                  head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap explicitly so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word reads, buffers responses, drops stale data after redirect.
// Optional performance counters are built when INSTR_FETCH_PERF_EN is defined.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
`ifdef INSTR_FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] S_RESET = ST_RESET;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_FLUSH = ST_FLUSH;

    logic [31:0]      fa_q, fa_d;
    logic [31:0]      rsp_addr_q, rsp_addr_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] disc_q, disc_d;
    logic [1:0]       state_q, state_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [63:0]      fifo_head;
    logic             req_fire, rsp_fire, push, pop;

    // Handshakes: a memory request transfers on mem_req && mem_gnt, an instruction
    // on instr_valid && instr_ready; each side holds its payload stable until then.
    assign req_fire = mem_req && mem_gnt;
    assign rsp_fire = mem_rvalid && (out_q != '0);
    assign push     = rsp_fire && (disc_q == '0) && !redirect;
    assign pop      = instr_valid && instr_ready && !redirect;

    assign mem_req  = reset && !redirect &&
                      (({1'b0, fifo_count} + {1'b0, out_q}) < (CNT_W + 1)'(DEPTH));
    assign mem_addr = fa_q;

    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? fifo_head[63:32] : '0;
    assign instr_addr  = instr_valid ? fifo_head[31:0]  : '0;
    assign dbg_state   = state_q;

    always_comb begin
        fa_d       = fa_q;
        rsp_addr_d = rsp_addr_q;
        disc_d     = disc_q;
        out_d      = out_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        if (req_fire) fa_d = fa_q + 32'd4;
        if (push)     rsp_addr_d = rsp_addr_q + 32'd4;
        if (rsp_fire && disc_q != '0) disc_d = disc_q - 1'b1;
        // Everything still in flight after a redirect belongs to the old stream.
        if (redirect) begin
            fa_d       = align_word(redirect_pc);
            rsp_addr_d = align_word(redirect_pc);
            disc_d     = out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = (disc_d != '0) ? S_FLUSH : S_RUN;
            S_RUN:   if (disc_d != '0) state_d = S_FLUSH;
            S_FLUSH: if (disc_d == '0) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fa_q       <= RESET_PC;
            rsp_addr_q <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            state_q    <= S_RESET;
        end else begin
            fa_q       <= fa_d;
            rsp_addr_q <= rsp_addr_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            state_q    <= state_d;
        end
    end

    instr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk),
        .rst_n_i     (reset),
        .push_i      (push),
        .push_data_i ({mem_rdata, rsp_addr_q}),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (state_q != S_RESET && !instr_valid) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the instruction buffer depth in entries (legal range 2..8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 instr  out  32  instruction word to the core.
REQ-006 instr_addr  out  32  address of instr.
REQ-007 instr_valid  out  1  instr/instr_addr valid.
REQ-008 instr_ready  in  1  core consumes instr this cycle.
REQ-009 redirect  in  1  non-sequential PC change (branch/jump taken).
REQ-010 redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-011 mem_req  out  1  memory read request.
REQ-012 mem_addr  out  32  word-aligned request address.
REQ-013 mem_gnt  in  1  request accepted this cycle.
REQ-014 mem_rvalid  in  1  read data valid.
REQ-015 mem_rdata  in  32  read data.

Function
REQ-016 Fetch address register (fa) SHALL increment by 4 on every mem_req && mem_gnt cycle.
REQ-017 mem_req SHALL be 1 only when buffer count + outstanding (granted, unanswered) < DEPTH and no redirect occurs that cycle.
REQ-018 Once asserted, mem_req and mem_addr SHALL stay stable until mem_gnt, except on redirect.
REQ-019 Responses SHALL be in order, arriving >=1 cycle after grant; each non-discarded response SHALL push {mem_rdata, address} into the FIFO.
REQ-020 instr_valid SHALL equal FIFO non-empty; instr/instr_addr SHALL show the FIFO head, combinationally from registered storage.
REQ-021 Pop SHALL occur on instr_valid && instr_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-023 On redirect: FIFO SHALL be emptied the same cycle (instr_valid=0 next cycle); fa SHALL load {redirect_pc[31:2],2'b00}; discard counter SHALL load the current outstanding count.
REQ-024 mem_rvalid while discard>0 SHALL decrement discard and SHALL NOT push.
REQ-025 Redirect SHALL take priority over simultaneous pop, push or grant; a grant coincident with redirect SHALL count as outstanding and be discarded.
REQ-026 mem_rvalid with zero outstanding SHALL be ignored.
REQ-027 FSM states: RESET (reset asserted) -> RUN (first cycle after deassertion); RUN -> FLUSH on redirect with outstanding>0; FLUSH -> RUN when discard reaches 0; in FLUSH new requests SHALL be issued when REQ-017 allows.

Reset
REQ-028 While reset=0: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_addr=0, fa=RESET_PC, count/outstanding/discard=0, FSM=RESET.
REQ-029 Reset mid-transaction SHALL abandon all outstanding requests; responses still arriving after release SHALL be ignored per REQ-026.
REQ-030 First mem_req SHALL assert in the first cycle after reset deassertion.

Configuration
REQ-031 Macro INSTR_FETCH_PERF_EN defined: outputs perf_fetched (32, increments per pop) and perf_stall (32, increments per cycle with instr_valid=0 outside RESET), both reset to 0, wrapping at 2^32.
REQ-032 Macro undefined: perf ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold the FSM state enum (RESET, RUN, FLUSH), NOP constant 32'h0000_0013 and instruction width constant 32.
REQ-034 One sub-module, instr_fetch_fifo (DEPTH-parameterised, push/pop/flush, count), SHALL hold the buffer.

Verification
REQ-035 Reset release, mem_gnt=1, rdata 1 cycle later = 32'h00C00193, 32'h40000033 -> mem_addr 0,4,8; instr_valid from cycle 3 with instr_addr 0 then 4.
REQ-036 instr_ready=0, DEPTH=2 -> after two responses mem_req=0; count stays 2; instr holds 32'h00C00193.
REQ-037 redirect with redirect_pc=32'h0000_0102 while 2 outstanding -> next mem_addr 32'h0000_0100; both stale responses dropped; FSM FLUSH then RUN; first delivered instr_addr 32'h100.
REQ-038 mem_gnt held 0 for 5 cycles -> mem_req=1 and mem_addr stable throughout; instr_valid=0.
REQ-039 reset asserted with 1 outstanding, response arrives after release -> ignored; first instr_addr = RESET_PC.
REQ-040 INSTR_FETCH_PERF_EN defined, 3 pops and 4 empty cycles -> perf_fetched=3, perf_stall=4.
